// File: rtl/priority_demux_1to6_if.sv
// Handshake bundle for the 1-to-6 priority demultiplexer: one input stream
// with a 5-bit priority select, six buffered output ports and the accept counter.
interface priority_demux_1to6_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] d_in;
  logic [4:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [WIDTH-1:0] d4;
  logic [WIDTH-1:0] d5;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic [CNT_W-1:0] accept_cnt;

  modport master (
    output d_in, sel, in_valid, out_ready,
    input  in_ready, d0, d1, d2, d3, d4, d5, out_valid, accept_cnt
  );

  modport slave (
    input  d_in, sel, in_valid, out_ready,
    output in_ready, d0, d1, d2, d3, d4, d5, out_valid, accept_cnt
  );
endinterface

// File: rtl/priority_demux_1to6.sv
// Registered 1-to-6 priority demultiplexer: each input word lands in the
// one-entry buffer of the port picked by the highest set sel bit.
module priority_demux_1to6 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  priority_demux_1to6_if.slave bus
);

  logic [2:0]       tgt_s;
  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] data_q [6];
  logic [WIDTH-1:0] data_d [6];
  logic [5:0]       valid_q;
  logic [5:0]       valid_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    casez (bus.sel)
      5'b1????: tgt_s = 3'd5;
      5'b01???: tgt_s = 3'd4;
      5'b001??: tgt_s = 3'd3;
      5'b0001?: tgt_s = 3'd2;
      5'b00001: tgt_s = 3'd1;
      default:  tgt_s = 3'd0;
    endcase
  end

  // A full buffer may still take a word when its consumer drains it this cycle.
  always_comb begin
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = ~valid_q[tgt_s] | bus.out_ready[tgt_s];
    end
    accept_s = bus.in_valid & in_ready_s;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~bus.out_ready;
    cnt_d   = cnt_q;
    if (accept_s) begin
      data_d[tgt_s]  = bus.d_in;
      valid_d[tgt_s] = 1'b1;
      cnt_d          = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= 6'b000000;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = valid_q;
  assign bus.accept_cnt = cnt_q;
  assign bus.d0         = data_q[0];
  assign bus.d1         = data_q[1];
  assign bus.d2         = data_q[2];
  assign bus.d3         = data_q[3];
  assign bus.d4         = data_q[4];
  assign bus.d5         = data_q[5];

endmodule
